sector_receiver: RTL and testbench

SECTOR_RECEIVER -- requirements
Module: sector_receiver

---
 rtl/sector_receiver.sv | 150 +++++++++++++++
 tb/tb_sector_receiver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sector_receiver.sv
// Serial sector-address receiver: start bit, 4 data bits MSB first, stop bit; mid-bit sampling
// of the synchronized line, with framing-error detection and good/error frame counters.
module sector_receiver #(
   parameter int BIT_CYCLES = 30
) (
   input  logic       clk_div16,
   input  logic       rst,
   input  logic       in_uart,
   output logic [3:0] sct_addr,
   output logic       sct_valid,
   output logic       addr_changed,
   output logic       frame_err,
   output logic [7:0] frame_cnt,
   output logic [7:0] err_cnt
);
   localparam int CW = $clog2(BIT_CYCLES);
   localparam logic [CW-1:0] CNT_HALF = CW'(BIT_CYCLES / 2 - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(BIT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t          state_q, state_d;
   logic            sync1_q, sync1_d, sync2_q, sync2_d;
   logic [1:0]      fill_q, fill_d;
   logic            prev_q, prev_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      bit_idx_q, bit_idx_d;
   logic [3:0]      shift_q, shift_d;
   logic [3:0]      sct_addr_q, sct_addr_d;
   logic            sct_valid_q, sct_valid_d;
   logic            addr_changed_q, addr_changed_d;
   logic            frame_err_q, frame_err_d;
   logic [7:0]      frame_cnt_q, frame_cnt_d;
   logic [7:0]      err_cnt_q, err_cnt_d;
   logic            rx_s;

   assign rx_s = sync2_q;

   always_comb begin
      state_d        = state_q;
      sync1_d        = in_uart;
      sync2_d        = sync1_q;
      fill_d         = {fill_q[0], 1'b1};
      // prev only reports high once rx_s carries a real line sample, so a
      // line held low through reset never looks like a falling edge
      prev_d         = rx_s & fill_q[1];
      cnt_d          = cnt_q;
      bit_idx_d      = bit_idx_q;
      shift_d        = shift_q;
      sct_addr_d     = sct_addr_q;
      sct_valid_d    = 1'b0;
      addr_changed_d = 1'b0;
      frame_err_d    = 1'b0;
      frame_cnt_d    = frame_cnt_q;
      err_cnt_d      = err_cnt_q;
      case (state_q)
         IDLE: begin
            if (!rx_s && prev_q) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = rx_s ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == CNT_FULL) begin
               shift_d   = {shift_q[2:0], rx_s};
               cnt_d     = '0;
               bit_idx_d = bit_idx_q + 1'b1;
               if (bit_idx_q == 2'd3)
                  state_d = STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d = '0;
               if (rx_s) begin
                  sct_addr_d     = shift_q;
                  sct_valid_d    = 1'b1;
                  addr_changed_d = (shift_q != sct_addr_q);
                  frame_cnt_d    = frame_cnt_q + 8'd1;
                  state_d        = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  if (err_cnt_q != 8'hFF)
                     err_cnt_d = err_cnt_q + 8'd1;
                  state_d = BREAK;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         BREAK: begin
            if (rx_s)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_div16 or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         sync1_q        <= 1'b1;
         sync2_q        <= 1'b1;
         fill_q         <= 2'b00;
         prev_q         <= 1'b0;
         cnt_q          <= '0;
         bit_idx_q      <= '0;
         shift_q        <= '0;
         sct_addr_q     <= '0;
         sct_valid_q    <= 1'b0;
         addr_changed_q <= 1'b0;
         frame_err_q    <= 1'b0;
         frame_cnt_q    <= '0;
         err_cnt_q      <= '0;
      end else begin
         state_q        <= state_d;
         sync1_q        <= sync1_d;
         sync2_q        <= sync2_d;
         fill_q         <= fill_d;
         prev_q         <= prev_d;
         cnt_q          <= cnt_d;
         bit_idx_q      <= bit_idx_d;
         shift_q        <= shift_d;
         sct_addr_q     <= sct_addr_d;
         sct_valid_q    <= sct_valid_d;
         addr_changed_q <= addr_changed_d;
         frame_err_q    <= frame_err_d;
         frame_cnt_q    <= frame_cnt_d;
         err_cnt_q      <= err_cnt_d;
      end
   end

   assign sct_addr     = sct_addr_q;
   assign sct_valid    = sct_valid_q;
   assign addr_changed = addr_changed_q;
   assign frame_err    = frame_err_q;
   assign frame_cnt    = frame_cnt_q;
   assign err_cnt      = err_cnt_q;
endmodule

// File: tb/tb_sector_receiver.sv
// Scoreboard bench for sector_receiver: a default-rate instance for directed frames and
// a fast instance (BIT_CYCLES=8) for counter saturation and wrap.
module tb_sector_receiver;
   localparam int BC  = 30;
   localparam int LAT = 2 + BC / 2 + 5 * BC;
   localparam int BCF = 8;

   logic       clk_div16 = 1'b0;
   logic       rst;
   logic       in_uart;
   logic       in_uart_f;
   logic [3:0] sct_addr, sct_addr_f;
   logic       sct_valid, sct_valid_f;
   logic       addr_changed, addr_changed_f;
   logic       frame_err, frame_err_f;
   logic [7:0] frame_cnt, frame_cnt_f;
   logic [7:0] err_cnt, err_cnt_f;

   sector_receiver #(.BIT_CYCLES(BC)) dut (
      .clk_div16(clk_div16), .rst(rst), .in_uart(in_uart),
      .sct_addr(sct_addr), .sct_valid(sct_valid), .addr_changed(addr_changed),
      .frame_err(frame_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
   );

   sector_receiver #(.BIT_CYCLES(BCF)) dut_fast (
      .clk_div16(clk_div16), .rst(rst), .in_uart(in_uart_f),
      .sct_addr(sct_addr_f), .sct_valid(sct_valid_f), .addr_changed(addr_changed_f),
      .frame_err(frame_err_f), .frame_cnt(frame_cnt_f), .err_cnt(err_cnt_f)
   );

   always #5 clk_div16 = ~clk_div16;

   int cyc = 0;
   always @(posedge clk_div16) cyc <= cyc + 1;

   typedef struct { int addr; int chg; int fcnt; int cyc; } vexp_t;
   typedef struct { int ecnt; int addr; } eexp_t;
   vexp_t vq[$];
   eexp_t eq[$];
   vexp_t ve;
   eexp_t ee;

   int n_cmp = 0;
   int n_bad = 0;
   int m_addr = 0;
   int m_fcnt = 0;
   int m_ecnt = 0;
   int n_ferr_f = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_div16);
      #1;
   endtask

   task automatic send_frame(input logic [3:0] a, input logic stop, input int stop_len);
      in_uart = 1'b0;
      tick(BC);
      for (int i = 3; i >= 0; i--) begin
         in_uart = a[i];
         tick(BC);
      end
      in_uart = stop;
      tick(stop_len);
      in_uart = 1'b1;
   endtask

   task automatic good_frame(input logic [3:0] a);
      vexp_t e;
      e.addr = int'(a);
      e.chg  = (int'(a) != m_addr) ? 1 : 0;
      m_fcnt = (m_fcnt + 1) % 256;
      e.fcnt = m_fcnt;
      e.cyc  = cyc + 1 + LAT;
      m_addr = int'(a);
      vq.push_back(e);
      send_frame(a, 1'b1, BC);
   endtask

   task automatic bad_frame(input logic [3:0] a, input int stop_len);
      eexp_t e;
      if (m_ecnt < 255) m_ecnt++;
      e.ecnt = m_ecnt;
      e.addr = m_addr;
      eq.push_back(e);
      send_frame(a, 1'b0, stop_len);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_sct_addr"}, int'(sct_addr), 0);
      chk({tag, "_sct_valid"}, int'(sct_valid), 0);
      chk({tag, "_addr_changed"}, int'(addr_changed), 0);
      chk({tag, "_frame_err"}, int'(frame_err), 0);
      chk({tag, "_frame_cnt"}, int'(frame_cnt), 0);
      chk({tag, "_err_cnt"}, int'(err_cnt), 0);
   endtask

   task automatic fast_frame(input logic [3:0] a, input logic stop, input int gap);
      in_uart_f = 1'b0;
      tick(BCF);
      for (int i = 3; i >= 0; i--) begin
         in_uart_f = a[i];
         tick(BCF);
      end
      in_uart_f = stop;
      tick(BCF);
      in_uart_f = 1'b1;
      tick(gap);
   endtask

   // Monitor: every output pulse must match the head of its expectation queue.
   always @(negedge clk_div16) begin
      if (!rst) begin
         if (sct_valid) begin
            chk("valid_has_expectation", (vq.size() > 0) ? 1 : 0, 1);
            if (vq.size() > 0) begin
               ve = vq.pop_front();
               chk("sct_addr", int'(sct_addr), ve.addr);
               chk("addr_changed", int'(addr_changed), ve.chg);
               chk("frame_cnt", int'(frame_cnt), ve.fcnt);
               chk("valid_cycle", cyc, ve.cyc);
            end
         end else if (addr_changed) begin
            chk("changed_without_valid", int'(sct_valid), 1);
         end
         if (frame_err) begin
            chk("err_with_valid", int'(sct_valid), 0);
            chk("err_has_expectation", (eq.size() > 0) ? 1 : 0, 1);
            if (eq.size() > 0) begin
               ee = eq.pop_front();
               chk("err_cnt", int'(err_cnt), ee.ecnt);
               chk("err_keeps_addr", int'(sct_addr), ee.addr);
            end
         end
      end
   end

   always @(negedge clk_div16) if (frame_err_f) n_ferr_f++;

   initial begin
      rst       = 1'b1;
      in_uart   = 1'b1;
      in_uart_f = 1'b1;
      tick(3);
      chk_all_zero("in_reset");
      rst = 1'b0;
      tick(5);
      chk_all_zero("after_reset");

      // Two identical frames back to back: second must not flag a change
      good_frame(4'hA);
      good_frame(4'hA);
      tick(20);

      // Short low glitch on an idle line
      in_uart = 1'b0;
      tick(10);
      in_uart = 1'b1;
      tick(60);
      chk("glitch_frame_cnt", int'(frame_cnt), m_fcnt);
      chk("glitch_err_cnt", int'(err_cnt), 0);

      // Stop bit held low, then recovery with a good frame
      bad_frame(4'h5, 2 * BC);
      tick(20);
      chk("after_err_addr", int'(sct_addr), 10);
      chk("after_err_cnt", int'(err_cnt), 1);
      good_frame(4'h3);
      tick(20);

      // Reset in the middle of the second data bit of 0xF
      in_uart = 1'b0;
      tick(BC);
      in_uart = 1'b1;
      tick(BC + BC / 2);
      rst = 1'b1;
      tick(3);
      chk_all_zero("mid_frame_reset");
      m_addr = 0;
      m_fcnt = 0;
      m_ecnt = 0;
      rst = 1'b0;
      tick(BC / 2 + 3 * BC + 10);
      chk_all_zero("after_mid_reset");
      good_frame(4'h6);
      tick(20);
      chk("final_addr", int'(sct_addr), 6);
      chk("final_frame_cnt", int'(frame_cnt), 1);
      chk("pending_valid", vq.size(), 0);
      chk("pending_err", eq.size(), 0);

      // Fast instance: error-count saturation, then frame-count wrap
      for (int i = 0; i < 300; i++) begin
         fast_frame(4'h0, 1'b0, 6);
         if (i == 254) chk("err_cnt_reaches_255", int'(err_cnt_f), 255);
      end
      tick(5);
      chk("err_cnt_saturated", int'(err_cnt_f), 255);
      chk("fast_err_pulses", n_ferr_f, 300);
      chk("fast_no_good_yet", int'(frame_cnt_f), 0);
      for (int i = 0; i < 256; i++) begin
         fast_frame(4'(i), 1'b1, 0);
         if (i == 254) chk("frame_cnt_255", int'(frame_cnt_f), 255);
      end
      tick(10);
      chk("frame_cnt_wrapped", int'(frame_cnt_f), 0);
      chk("fast_last_addr", int'(sct_addr_f), 15);
      chk("fast_err_held", int'(err_cnt_f), 255);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
